alu_cmd_sequencer: RTL and testbench

Initiator side of the ALU operand/result interface. Accepts one ALU command per valid/ready handshake and registers the command onto the ALU input bus. Waits a fixed settle time, then captures out/odd_parity/invalid and returns them on a valid/ready response channel. Sits between a command source (CPU-side register block or test sequencer) and the combinational ALU, and keeps a saturating count of invalid results.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_sat_counter.sv | 25 ++
 rtl/alu_cmd_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command path: opcodes, control bit map
// and the sequencer state encoding.
package alu_pkg;

   // ALU opcodes; 3'b110 and 3'b111 are reserved and report invalid.
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_XOR = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_DIV = 3'b101;

   // Bit positions inside the 6-bit control word.
   localparam int CTRL_FA    = 5;
   localparam int CTRL_CIN   = 4;
   localparam int CTRL_RED_A = 3;
   localparam int CTRL_RED_B = 2;
   localparam int CTRL_BYP_A = 1;
   localparam int CTRL_BYP_B = 0;

   // Settle counter width; covers the full 1..15 settle range.
   localparam int SETTLE_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } seq_state_t;

endpackage

// File: rtl/alu_sat_counter.sv
// Saturating up-counter with a clear that wins over a coincident increment.
module alu_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_reg;

   // Clear has priority; increments stop once the counter is all-ones.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count_reg <= '0;
      end else if (inc && (count_reg != '1)) begin
         count_reg <= count_reg + CNT_W'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for the combinational ALU: registers one command onto the ALU
// input bus, waits SETTLE cycles, captures the result and offers it on a
// valid/ready response channel. Tracks how many results came back invalid.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 2,
   parameter int CNT_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [2:0]         cmd_opcode,
   input  logic [WIDTH:0]     cmd_a,
   input  logic [WIDTH:0]     cmd_b,
   input  logic [5:0]         cmd_ctrl,
   output logic [2:0]         alu_opcode,
   output logic [WIDTH:0]     alu_A,
   output logic [WIDTH:0]     alu_B,
   output logic [5:0]         alu_ctrl,
   input  logic [2*WIDTH:0]   alu_out,
   input  logic               alu_odd_parity,
   input  logic               alu_invalid,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [2*WIDTH:0]   rsp_out,
   output logic               rsp_odd_parity,
   output logic               rsp_invalid,
   output logic [CNT_W-1:0]   invalid_cnt,
   input  logic               cnt_clr,
   output logic               busy
);

   localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE - 1);

   // The SETTLE parameter shadows the enum member, so states are always
   // referenced through the package scope in this file.
   seq_state_t state_reg, state_next;

   logic [SETTLE_CNT_W-1:0] settle_cnt_reg;
   logic [2:0]              alu_opcode_reg;
   logic [WIDTH:0]          alu_a_reg;
   logic [WIDTH:0]          alu_b_reg;
   logic [5:0]              alu_ctrl_reg;
   logic [2*WIDTH:0]        rsp_out_reg;
   logic                    rsp_odd_parity_reg;
   logic                    rsp_invalid_reg;

   logic accept;
   logic capture;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= alu_pkg::IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state: accept moves to SETTLE, counter expiry to RESP, handshake back to IDLE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         alu_pkg::IDLE: begin
            if (cmd_valid) state_next = alu_pkg::SETTLE;
         end
         alu_pkg::SETTLE: begin
            if (settle_cnt_reg == '0) state_next = alu_pkg::RESP;
         end
         alu_pkg::RESP: begin
            if (rsp_ready) state_next = alu_pkg::IDLE;
         end
         default: state_next = alu_pkg::IDLE;
      endcase
   end

   // Outputs and strobes decoded from the current state.
   always_comb begin
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      capture   = 1'b0;
      case (state_reg)
         alu_pkg::IDLE: begin
            cmd_ready = !rst;
            accept    = cmd_valid && !rst;
         end
         alu_pkg::SETTLE: begin
            busy    = 1'b1;
            capture = (settle_cnt_reg == '0);
         end
         alu_pkg::RESP: begin
            busy      = 1'b1;
            rsp_valid = 1'b1;
         end
         default: begin
            busy = 1'b1;
         end
      endcase
   end

   // Datapath: command registers hold until the next accept, response
   // registers hold until the next capture, settle counter runs in SETTLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         settle_cnt_reg     <= '0;
         alu_opcode_reg     <= '0;
         alu_a_reg          <= '0;
         alu_b_reg          <= '0;
         alu_ctrl_reg       <= '0;
         rsp_out_reg        <= '0;
         rsp_odd_parity_reg <= 1'b0;
         rsp_invalid_reg    <= 1'b0;
      end else begin
         if (accept) begin
            alu_opcode_reg <= cmd_opcode;
            alu_a_reg      <= cmd_a;
            alu_b_reg      <= cmd_b;
            alu_ctrl_reg   <= cmd_ctrl;
            settle_cnt_reg <= SETTLE_LOAD;
         end else if ((state_reg == alu_pkg::SETTLE) && (settle_cnt_reg != '0)) begin
            settle_cnt_reg <= settle_cnt_reg - SETTLE_CNT_W'(1);
         end
         if (capture) begin
            rsp_out_reg        <= alu_out;
            rsp_odd_parity_reg <= alu_odd_parity;
            rsp_invalid_reg    <= alu_invalid;
         end
      end
   end

   alu_sat_counter #(
      .CNT_W (CNT_W)
   ) u_invalid_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (capture && alu_invalid),
      .clr   (cnt_clr),
      .count (invalid_cnt)
   );

   assign alu_opcode     = alu_opcode_reg;
   assign alu_A          = alu_a_reg;
   assign alu_B          = alu_b_reg;
   assign alu_ctrl       = alu_ctrl_reg;
   assign rsp_out        = rsp_out_reg;
   assign rsp_odd_parity = rsp_odd_parity_reg;
   assign rsp_invalid    = rsp_invalid_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small behavioural ALU stub.
module tb_alu_cmd_sequencer;
   import alu_pkg::*;

   localparam int W  = 4;
   localparam int ST = 2;
   localparam int CW = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [2:0]       cmd_opcode = '0;
   logic [W:0]       cmd_a = '0;
   logic [W:0]       cmd_b = '0;
   logic [5:0]       cmd_ctrl = '0;
   logic [2:0]       alu_opcode;
   logic [W:0]       alu_A;
   logic [W:0]       alu_B;
   logic [5:0]       alu_ctrl;
   logic [2*W:0]     alu_out;
   logic             alu_odd_parity;
   logic             alu_invalid;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [2*W:0]     rsp_out;
   logic             rsp_odd_parity;
   logic             rsp_invalid;
   logic [CW-1:0]    invalid_cnt;
   logic             cnt_clr = 1'b0;
   logic             busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_cmd_sequencer #(
      .WIDTH (W), .SETTLE (ST), .CNT_W (CW)
   ) dut (
      .clk (clk), .rst (rst),
      .cmd_valid (cmd_valid), .cmd_ready (cmd_ready),
      .cmd_opcode (cmd_opcode), .cmd_a (cmd_a), .cmd_b (cmd_b), .cmd_ctrl (cmd_ctrl),
      .alu_opcode (alu_opcode), .alu_A (alu_A), .alu_B (alu_B), .alu_ctrl (alu_ctrl),
      .alu_out (alu_out), .alu_odd_parity (alu_odd_parity), .alu_invalid (alu_invalid),
      .rsp_valid (rsp_valid), .rsp_ready (rsp_ready),
      .rsp_out (rsp_out), .rsp_odd_parity (rsp_odd_parity), .rsp_invalid (rsp_invalid),
      .invalid_cnt (invalid_cnt), .cnt_clr (cnt_clr), .busy (busy)
   );

   // ALU stub: enough arithmetic for the directed vectors; reserved opcodes
   // return 0 with parity 0 and invalid set.
   always_comb begin
      alu_out        = '0;
      alu_invalid    = 1'b0;
      alu_odd_parity = 1'b0;
      case (alu_opcode)
         OP_AND: alu_out = 9'(alu_A & alu_B);
         OP_XOR: alu_out = 9'(alu_A ^ alu_B);
         OP_ADD: alu_out = 9'(alu_A) + 9'(alu_B) + 9'(alu_ctrl[CTRL_FA] & alu_ctrl[CTRL_CIN]);
         OP_MUL: alu_out = 9'(alu_A) * 9'(alu_B);
         OP_SUB: alu_out = 9'(alu_A) - 9'(alu_B);
         OP_DIV: begin
            if (alu_B == '0) begin
               alu_out     = 9'(alu_A);
               alu_invalid = 1'b1;
            end else begin
               alu_out = 9'(alu_A / alu_B);
            end
         end
         default: alu_invalid = 1'b1;
      endcase
      if (alu_opcode inside {OP_AND, OP_XOR, OP_ADD, OP_MUL, OP_SUB, OP_DIV})
         alu_odd_parity = ~^alu_out;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer a command and return just after the edge that accepts it.
   task automatic send(input logic [2:0] op, input logic [W:0] a, input logic [W:0] b,
                       input logic [5:0] ctrl);
      int n = 0;
      cmd_valid  = 1'b1;
      cmd_opcode = op;
      cmd_a      = a;
      cmd_b      = b;
      cmd_ctrl   = ctrl;
      while (!cmd_ready && n < 40) begin
         tick();
         n++;
      end
      check("accept_wait", 32'(n < 40), 32'd1);
      tick();
      cmd_valid = 1'b0;
      check("alu_opcode", 32'(alu_opcode), 32'(op));
      check("alu_A", 32'(alu_A), 32'(a));
      check("alu_B", 32'(alu_B), 32'(b));
      check("alu_ctrl", 32'(alu_ctrl), 32'(ctrl));
      check("busy_after_accept", 32'(busy), 32'd1);
      check("cmd_ready_after_accept", 32'(cmd_ready), 32'd0);
   endtask

   // Count edges from accept to rsp_valid; optionally pulse cnt_clr on the capture edge.
   task automatic wait_rsp(input bit clr_on_capture);
      int n = 0;
      while (!rsp_valid && n < 40) begin
         if (clr_on_capture && n == ST - 1) cnt_clr = 1'b1;
         tick();
         cnt_clr = 1'b0;
         n++;
      end
      check("rsp_latency", 32'(n), 32'(ST));
   endtask

   task automatic take(input logic [8:0] exp_out);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
      check("cmd_ready_after_hs", 32'(cmd_ready), 32'd1);
      check("rsp_out_held", 32'(rsp_out), 32'(exp_out));
   endtask

   task automatic run(input string tag, input logic [2:0] op, input logic [W:0] a,
                      input logic [W:0] b, input logic [5:0] ctrl,
                      input logic [8:0] exp_out, input logic exp_par, input logic exp_inv,
                      input logic [CW-1:0] exp_cnt, input bit clr_on_capture);
      send(op, a, b, ctrl);
      wait_rsp(clr_on_capture);
      check({tag, "_out"}, 32'(rsp_out), 32'(exp_out));
      check({tag, "_par"}, 32'(rsp_odd_parity), 32'(exp_par));
      check({tag, "_inv"}, 32'(rsp_invalid), 32'(exp_inv));
      check({tag, "_cnt"}, 32'(invalid_cnt), 32'(exp_cnt));
      $display("txn %s op=%b A=%0d B=%0d ctrl=%b out=%0d par=%b inv=%b cnt=%0d",
               tag, op, a, b, ctrl, rsp_out, rsp_odd_parity, rsp_invalid, invalid_cnt);
      take(exp_out);
   endtask

   initial begin
      logic [CW-1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      // Reset held with a command offered: nothing accepted, everything 0.
      cmd_valid  = 1'b1;
      cmd_opcode = OP_ADD;
      cmd_a      = 5'd5;
      cmd_b      = 5'd3;
      cmd_ctrl   = 6'b110000;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
         check("rst_alu", 32'({alu_opcode, alu_A, alu_B, alu_ctrl}), 32'd0);
         check("rst_rsp", 32'({rsp_valid, rsp_out, rsp_odd_parity, rsp_invalid}), 32'd0);
         check("rst_cnt_busy", 32'({invalid_cnt, busy}), 32'd0);
      end
      rst = 1'b0;
      #1;
      check("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);

      // ADD with full adder and carry-in: 5+3+1 = 9.
      run("add", OP_ADD, 5'd5, 5'd3, 6'b110000, 9'd9, 1'b1, 1'b0, 2'd0, 1'b0);

      // Backpressure: response held for 5 cycles while a second command waits.
      send(OP_ADD, 5'd5, 5'd3, 6'b110000);
      wait_rsp(1'b0);
      cmd_valid  = 1'b1;
      cmd_opcode = OP_MUL;
      cmd_a      = 5'd7;
      cmd_b      = 5'd3;
      cmd_ctrl   = 6'b000000;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rsp_out", 32'(rsp_out), 32'd9);
         check("bp_rsp_flags", 32'({rsp_odd_parity, rsp_invalid}), 32'b10);
         check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
         check("bp_alu_hold", 32'(alu_opcode), 32'(OP_ADD));
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("bp_hs_rsp_valid", 32'(rsp_valid), 32'd0);
      check("bp_no_accept_on_fall", 32'(alu_opcode), 32'(OP_ADD));
      check("bp_cmd_ready_next", 32'(cmd_ready), 32'd1);
      run("mul", OP_MUL, 5'd7, 5'd3, 6'b000000, 9'd21, 1'b0, 1'b0, 2'd0, 1'b0);

      // Invalid results feed the counter.
      run("div0", OP_DIV, 5'd6, 5'd0, 6'b000000, 9'd6, 1'b1, 1'b1, 2'd1, 1'b0);
      run("rsv110", 3'b110, 5'd9, 5'd17, 6'b011100, 9'd0, 1'b0, 1'b1, 2'd2, 1'b0);

      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check("cnt_clr_idle", 32'(invalid_cnt), 32'd0);

      // Saturation at all-ones with a 2-bit counter.
      for (int i = 0; i < 5; i++) begin
         run("sat", 3'b111, 5'(i), 5'(i + 1), 6'(i * 7), 9'd0, 1'b0, 1'b1, sat_exp[i], 1'b0);
      end

      // Clear coincident with an invalid capture wins.
      run("clr_cap", OP_DIV, 5'd9, 5'd0, 6'b000000, 9'd9, 1'b1, 1'b1, 2'd0, 1'b1);

      // Reset on the edge that would capture: command dropped, no response.
      run("div1", OP_DIV, 5'd4, 5'd0, 6'b000000, 9'd4, 1'b0, 1'b1, 2'd1, 1'b0);
      send(3'b110, 5'd1, 5'd2, 6'b001100);
      tick();
      check("mid_settle_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_alu", 32'({alu_opcode, alu_A, alu_B, alu_ctrl}), 32'd0);
      check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_mid_cnt", 32'(invalid_cnt), 32'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
      end

      // Normal operation resumes: 3-5 wraps to 9'h1FE.
      run("sub", OP_SUB, 5'd3, 5'd5, 6'b000000, 9'h1FE, 1'b1, 1'b0, 2'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
